// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: keypad operand entry (A/B, 0-127) and divider start/completion sequencer.
// Optional DIV_WATCHDOG_EN adds a TIMEOUT_CYC watchdog on the divider's completion.
module operand_entry_fsm #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       div_busy,
  input  logic       div_done,
  output logic [6:0] A_out,
  output logic [6:0] B_out,
  output logic       start,
  output logic [6:0] entry_val,
  output logic       field,
  output logic       result_valid,
  output logic       err_ovf,
  output logic       err_div0,
  output logic       err_timeout
);
  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, WAIT_DIV, SHOW} state_t;
  state_t      state;
  logic [3:0]  d2, d1, d0;
  logic [1:0]  cnt;
  logic [7:0]  cur_val, bs_val;
  logic [10:0] push_val;
  logic        is_digit, is_enter, is_bs, is_clr, fits;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  assign cur_val  = {4'd0, d2} * 8'd100 + {4'd0, d1} * 8'd10 + {4'd0, d0};
  assign bs_val   = {4'd0, d2} * 8'd10 + {4'd0, d1};
  assign push_val = {3'd0, cur_val} * 11'd10 + {7'd0, key};
  assign is_digit = key <= 4'd9;
  assign is_enter = key == 4'hA;
  assign is_bs    = key == 4'hB;
  assign is_clr   = key == 4'hC;
  assign fits     = cnt != 2'd3 && push_val <= 11'd127;

`ifdef DIV_WATCHDOG_EN
  logic [15:0] wd;
  logic        wd_expired;
  assign wd_expired = wd == 16'(TIMEOUT_CYC - 1);
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ENTRY_A;
      d2           <= '0;
      d1           <= '0;
      d0           <= '0;
      cnt          <= '0;
      A_out        <= '0;
      B_out        <= '0;
      start        <= 1'b0;
      entry_val    <= '0;
      field        <= 1'b0;
      result_valid <= 1'b0;
      err_ovf      <= 1'b0;
      err_div0     <= 1'b0;
`ifdef DIV_WATCHDOG_EN
      err_timeout  <= 1'b0;
      wd           <= '0;
`endif
    end else begin
      start   <= 1'b0;
      err_ovf <= 1'b0;
      case (state)
        ENTRY_A, ENTRY_B: if (key_valid) begin
          if (is_digit) begin
            if (fits) begin
              d2        <= d1;
              d1        <= d0;
              d0        <= key;
              cnt       <= cnt + 2'd1;
              entry_val <= push_val[6:0];
              if (state == ENTRY_B) err_div0 <= 1'b0;
            end else begin
              err_ovf <= 1'b1;
            end
          end else if (is_bs && cnt != 2'd0) begin
            d0        <= d1;
            d1        <= d2;
            d2        <= '0;
            cnt       <= cnt - 2'd1;
            entry_val <= bs_val[6:0];
          end else if (is_enter && cnt != 2'd0) begin
            if (state == ENTRY_A) begin
              A_out     <= cur_val[6:0];
              d2        <= '0;
              d1        <= '0;
              d0        <= '0;
              cnt       <= '0;
              entry_val <= '0;
              state     <= ENTRY_B;
              field     <= 1'b1;
            end else if (!div_busy) begin
              if (cur_val == 8'd0) begin
                err_div0 <= 1'b1;
              end else begin
                B_out <= cur_val[6:0];
                start <= 1'b1;
                state <= WAIT_DIV;
                field <= 1'b0;
`ifdef DIV_WATCHDOG_EN
                wd    <= '0;
`endif
              end
            end
          end else if (is_clr) begin
            d2        <= '0;
            d1        <= '0;
            d0        <= '0;
            cnt       <= '0;
            entry_val <= '0;
            // an already-empty B buffer backs out to operand A
            if (state == ENTRY_B && cnt == 2'd0) begin
              state    <= ENTRY_A;
              field    <= 1'b0;
              err_div0 <= 1'b0;
            end
          end
        end
        WAIT_DIV: begin
          if (div_done) begin
            state        <= SHOW;
            result_valid <= 1'b1;
          end
`ifdef DIV_WATCHDOG_EN
          else if (wd_expired) begin
            state        <= SHOW;
            result_valid <= 1'b1;
            err_timeout  <= 1'b1;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        SHOW: if (key_valid) begin
          if (is_digit) begin
            d2           <= '0;
            d1           <= '0;
            d0           <= key;
            cnt          <= 2'd1;
            entry_val    <= {3'd0, key};
            state        <= ENTRY_A;
            result_valid <= 1'b0;
          end else if (is_clr) begin
            d2           <= '0;
            d1           <= '0;
            d0           <= '0;
            cnt          <= '0;
            entry_val    <= '0;
            state        <= ENTRY_A;
            result_valid <= 1'b0;
`ifdef DIV_WATCHDOG_EN
            err_timeout  <= 1'b0;
`endif
          end else if (is_enter) begin
            start        <= 1'b1;
            state        <= WAIT_DIV;
            result_valid <= 1'b0;
`ifdef DIV_WATCHDOG_EN
            wd           <= '0;
`endif
          end
        end
        default: state <= ENTRY_A;
      endcase
    end
  end
endmodule
